// File: rtl/lenet_pkg.sv
// -----------------------------------------------------------------------------
// lenet_pkg
//   Shared definitions for the LeNet accelerator layer scheduler:
//   layer index constants, the scheduler state encoding and the layer count.
//   The helper turns a cycle count into the value loaded into seq_timer.
// -----------------------------------------------------------------------------
package lenet_pkg;

  localparam int NUM_LAYERS = 5;
  localparam int LAYER_W    = 3;   // width of layer index / fm_sel / cur_layer
  localparam int TMR_W      = 8;   // width of the shared phase timer

  localparam logic [LAYER_W-1:0] L_CONV1 = 3'd0;
  localparam logic [LAYER_W-1:0] L_POOL1 = 3'd1;
  localparam logic [LAYER_W-1:0] L_CONV2 = 3'd2;
  localparam logic [LAYER_W-1:0] L_POOL2 = 3'd3;
  localparam logic [LAYER_W-1:0] L_FC    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_FIN   = 3'd5,
    S_ERR   = 3'd6
  } state_e;

  // The timer reaches zero after 'cycles' clocks when loaded with cycles-1.
  function automatic logic [TMR_W-1:0] tmr_load_val(input int cycles);
    return TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/seq_timer.sv
// -----------------------------------------------------------------------------
// seq_timer
//   Loadable down-counter with a zero flag. Counts down by one per clock while
//   non-zero and parks at zero. A load takes priority over counting.
// Ports
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset (counter clears to zero)
//   i_load     in  load i_load_val on this clock
//   i_load_val in  value to load
//   o_zero     out counter is zero
// -----------------------------------------------------------------------------
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lenet_layer_seq.sv
// -----------------------------------------------------------------------------
// lenet_layer_seq
//   Layer scheduler for the LeNet accelerator. After one start pulse it runs
//   conv_1, pool_1, conv_2, pool_2 and fc one at a time: reset the engine,
//   release reset, wait for a clean (low) finish flag, enable the engine, wait
//   for finish, keep the enable up while the store pipeline drains, move on.
//   It owns the shared feature-map BRAM select and flags hung layers.
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   start        in   one-cycle start pulse, accepted only in IDLE
//   abort        in   level; orderly stop from any busy state
//   tmo_limit    in   max ARM/RUN cycles per layer, 0 disables the watchdog
//   layer_finish in   sticky finish flags from the layer engines
//   layer_en     out  one-hot level enable of the active layer
//   layer_rst    out  active-high sync reset to each layer engine
//   fm_sel       out  shared FM BRAM owner; holds last owner through DRAIN
//   cur_layer    out  index of the active layer
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse after the last layer drains
//   err          out  sticky watchdog/abort flag, cleared by the next start
// -----------------------------------------------------------------------------
module lenet_layer_seq #(
  parameter int NUM_LAYERS = 5,
  parameter int RST_CYC    = 4,
  parameter int DRAIN_CYC  = 8,
  parameter int TMO_W      = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TMO_W-1:0]      tmo_limit,
  input  logic [NUM_LAYERS-1:0] layer_finish,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic [NUM_LAYERS-1:0] layer_rst,
  output logic [2:0]            fm_sel,
  output logic [2:0]            cur_layer,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  import lenet_pkg::*;

  localparam logic [TMR_W-1:0]   RST_LOAD   = tmr_load_val(RST_CYC);
  localparam logic [TMR_W-1:0]   DRAIN_LOAD = tmr_load_val(DRAIN_CYC);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);

  state_e                  r_state;
  logic [NUM_LAYERS-1:0]   r_layer_en;
  logic [NUM_LAYERS-1:0]   r_layer_rst;
  logic [LAYER_W-1:0]      r_fm_sel;
  logic [LAYER_W-1:0]      r_cur_layer;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [TMO_W-1:0]        r_wdog;

  logic [NUM_LAYERS-1:0]   w_onehot;
  logic                    w_fin_cur;
  logic                    w_abort_go;
  logic [TMO_W-1:0]        w_wdog_inc;
  logic                    w_timeout;
  logic                    w_tmr_load;
  logic [TMR_W-1:0]        w_tmr_val;
  logic                    w_tmr_zero;

  assign w_onehot  = NUM_LAYERS'(1) << r_cur_layer;
  assign w_fin_cur = |(layer_finish & w_onehot);

  // Abort is meaningless when idle, and ERR is already the orderly stop.
  assign w_abort_go = abort && (r_state != S_IDLE) && (r_state != S_ERR);

  // Watchdog saturates instead of wrapping so a huge limit cannot be skipped.
  assign w_wdog_inc = (&r_wdog) ? r_wdog : r_wdog + TMO_W'(1);
  assign w_timeout  = (tmo_limit != '0) && (w_wdog_inc >= tmo_limit);

  // The timer is kept loaded in every untimed state, so whichever timed phase
  // comes next (CLR, DRAIN or ERR) starts from the right count on its entry
  // edge. RUN is the only state that can enter DRAIN, hence the only place
  // the drain count is selected.
  always_comb begin
    // NOTE: defaults first so every path assigns these and no latch is inferred.
    w_tmr_load = 1'b1;
    w_tmr_val  = RST_LOAD;
    case (r_state)
      S_CLR, S_ERR: w_tmr_load = w_abort_go;
      S_DRAIN:      w_tmr_load = w_abort_go || w_tmr_zero;
      S_RUN:        if (w_fin_cur && !w_abort_go) w_tmr_val = DRAIN_LOAD;
      default:      w_tmr_load = 1'b1;
    endcase
  end

  seq_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_layer_en  <= '0;
      r_layer_rst <= '1;
      r_fm_sel    <= '0;
      r_cur_layer <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_wdog      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_done <= 1'b0;
      if (w_abort_go) begin
        // Abort wins over a same-cycle finish or timeout.
        r_state     <= S_ERR;
        r_err       <= 1'b1;
        r_layer_en  <= '0;
        r_layer_rst <= '1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_layer_en  <= '0;
            r_layer_rst <= '1;
            if (start) begin
              r_state     <= S_CLR;
              r_cur_layer <= L_CONV1;
              r_err       <= 1'b0;
              r_busy      <= 1'b1;
            end
          end

          S_CLR: begin
            if (w_tmr_zero) begin
              r_state     <= S_ARM;
              r_layer_rst <= ~w_onehot;
              r_wdog      <= '0;
            end
          end

          // A finish flag still high after the engine was reset is stale;
          // only the watchdog can get us out of here.
          S_ARM: begin
            if (!w_fin_cur) begin
              r_state    <= S_RUN;
              r_layer_en <= w_onehot;
              r_fm_sel   <= r_cur_layer;
              r_wdog     <= '0;
            end else if (w_timeout) begin
              r_state     <= S_ERR;
              r_err       <= 1'b1;
              r_layer_rst <= '1;
            end else begin
              r_wdog <= w_wdog_inc;
            end
          end

          S_RUN: begin
            if (w_fin_cur) begin
              r_state <= S_DRAIN;
            end else if (w_timeout) begin
              r_state     <= S_ERR;
              r_err       <= 1'b1;
              r_layer_en  <= '0;
              r_layer_rst <= '1;
            end else begin
              r_wdog <= w_wdog_inc;
            end
          end

          // Enable and fm_sel stay put so delayed BRAM writes still land.
          S_DRAIN: begin
            if (w_tmr_zero) begin
              r_layer_en  <= '0;
              r_layer_rst <= '1;
              if (r_cur_layer == LAST_LAYER) begin
                r_state <= S_FIN;
                r_done  <= 1'b1;
              end else begin
                r_state     <= S_CLR;
                r_cur_layer <= r_cur_layer + LAYER_W'(1);
              end
            end
          end

          S_FIN: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end

          S_ERR: begin
            if (w_tmr_zero) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end

          default: begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_layer_en  <= '0;
            r_layer_rst <= '1;
          end
        endcase
      end
    end
  end

  assign layer_en  = r_layer_en;
  assign layer_rst = r_layer_rst;
  assign fm_sel    = r_fm_sel;
  assign cur_layer = r_cur_layer;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_lenet_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_lenet_layer_seq
//   Directed bench for the LeNet layer scheduler. A small engine model per
//   layer raises a sticky finish about 100 enabled cycles after its enable,
//   cleared by its layer_rst; force_fin and model_on let scenarios fake stale
//   or missing finishes. Inputs change at negedge (or 2 units after posedge
//   for the engine model); outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_lenet_layer_seq;

  localparam int N        = 5;
  localparam int TMO_W    = 20;
  localparam int WAIT_MAX = 2000;

  logic             clk = 1'b0;
  logic             rst_n, start, abort;
  logic [TMO_W-1:0] tmo_limit;
  logic [N-1:0]     layer_finish, layer_en, layer_rst;
  logic [2:0]       fm_sel, cur_layer;
  logic             busy, done, err;

  logic [N-1:0]     model_on  = '1;
  logic [N-1:0]     force_fin = '0;
  logic [N-1:0]     fin_model = '0;
  int               mcnt [N];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int inv_bad  = 0;

  always #5 clk = ~clk;

  lenet_layer_seq #(
    .NUM_LAYERS (N),
    .RST_CYC    (4),
    .DRAIN_CYC  (8),
    .TMO_W      (TMO_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .tmo_limit    (tmo_limit),
    .layer_finish (layer_finish),
    .layer_en     (layer_en),
    .layer_rst    (layer_rst),
    .fm_sel       (fm_sel),
    .cur_layer    (cur_layer),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  // Layer engine model: sticky finish, cleared only by its own sync reset.
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < N; k++) begin
      if (layer_rst[k]) begin
        fin_model[k] <= 1'b0;
        mcnt[k]      <= 0;
      end else if (layer_en[k]) begin
        if (mcnt[k] < 100) mcnt[k] <= mcnt[k] + 1;
        if (mcnt[k] == 99 && model_on[k]) fin_model[k] <= 1'b1;
      end
    end
  end

  assign layer_finish = fin_model | force_fin;

  // Pulse counter and structural invariants, sampled on the pre-edge values.
  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (rst_n && (($countones(layer_en) > 1) || ((layer_en & layer_rst) != '0)))
      inv_bad <= inv_bad + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got no end want end");
    $fatal(1, "global timeout");
  end

  // ---------------- bounded wait helpers (expiry counts as a failure) -------
  task automatic wait_en(input int k, input logic v, output int n);
    n = 0;
    while (layer_en[k] !== v) begin
      @(negedge clk); n++;
      if (n > WAIT_MAX) begin
        total++; bad++;
        $display("FAIL wait_en[%0d]=%0b: timed out, got %0b want %0b", k, v, layer_en[k], v);
        n = -1; return;
      end
    end
  endtask

  task automatic wait_fin(input int k);
    int n = 0;
    while (layer_finish[k] !== 1'b1) begin
      @(negedge clk); n++;
      if (n > WAIT_MAX) begin
        total++; bad++;
        $display("FAIL wait_fin[%0d]: timed out, got 0 want 1", k);
        return;
      end
    end
  endtask

  task automatic wait_rst_low(input int k);
    int n = 0;
    while (layer_rst[k] !== 1'b0) begin
      @(negedge clk); n++;
      if (n > WAIT_MAX) begin
        total++; bad++;
        $display("FAIL wait_rst_low[%0d]: timed out, got 1 want 0", k);
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0) begin
      @(negedge clk); n++;
      if (n > WAIT_MAX) begin
        total++; bad++;
        $display("FAIL wait_idle: timed out, got busy=%0b want 0", busy);
        return;
      end
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // ---------------- scenarios -------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tmo_limit = '0;
    repeat (3) @(negedge clk);
    total++; if (layer_en !== 5'h00) begin bad++; $display("FAIL reset_en: got %h want 00", layer_en); end
    total++; if (layer_rst !== 5'h1f) begin bad++; $display("FAIL reset_rst: got %h want 1f", layer_rst); end
    total++; if (fm_sel !== 3'd0) begin bad++; $display("FAIL reset_fm_sel: got %0d want 0", fm_sel); end
    total++; if (cur_layer !== 3'd0) begin bad++; $display("FAIL reset_cur: got %0d want 0", cur_layer); end
    total++; if ({busy, done, err} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (layer_rst !== 5'h1f || busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: got rst=%h busy=%0b want 1f 0", layer_rst, busy); end
  endtask

  task automatic test_happy_path();
    int n;
    int d0;
    logic [N-1:0] exp_en;
    tmo_limit = '0; model_on = '1;
    d0 = done_cnt;
    pulse_start();
    for (int k = 0; k < N; k++) begin
      exp_en = N'(1) << k;
      wait_en(k, 1'b1, n);
      total++; if (layer_en !== exp_en) begin bad++; $display("FAIL happy_en[%0d]: got %b want %b", k, layer_en, exp_en); end
      total++; if (fm_sel !== 3'(k) || cur_layer !== 3'(k)) begin bad++; $display("FAIL happy_sel[%0d]: got fm=%0d cur=%0d want %0d", k, fm_sel, cur_layer, k); end
      wait_en(k, 1'b0, n);
      total++; if (fm_sel !== 3'(k)) begin bad++; $display("FAIL happy_fm_hold[%0d]: got %0d want %0d", k, fm_sel, k); end
    end
    wait_idle();
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL happy_done: got %0d pulses want 1", done_cnt - d0); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL happy_err: got %0b want 0", err); end
  endtask

  task automatic test_abort_idle(input logic exp_err);
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    total++; if (err !== exp_err || busy !== 1'b0) begin bad++; $display("FAIL abort_idle: got err=%0b busy=%0b want %0b 0", err, busy, exp_err); end
  endtask

  task automatic test_latency();
    int n;
    tmo_limit = TMO_W'(1000); model_on = '1;
    @(negedge clk); start = 1'b1; n = 0;
    do begin @(negedge clk); start = 1'b0; n++; end while (layer_en[0] !== 1'b1 && n < 100);
    total++; if (n !== 6) begin bad++; $display("FAIL lat_start_en0: got %0d cycles want 6", n); end
    wait_fin(0);
    n = 0;
    while (layer_en[1] !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    total++; if (n !== 14) begin bad++; $display("FAIL lat_fin0_en1: got %0d cycles want 14", n); end
    wait_idle();
  endtask

  task automatic test_stale_finish();
    int n;
    logic seen;
    tmo_limit = TMO_W'(1000); model_on = '1;
    pulse_start();
    wait_en(1, 1'b1, n);
    force_fin = 5'b00100;
    wait_rst_low(2);
    tmo_limit = TMO_W'(50);
    n = 0; seen = 1'b0;
    while (err !== 1'b1 && n < 500) begin
      @(negedge clk); n++;
      if (layer_en[2]) seen = 1'b1;
    end
    total++; if (n !== 50) begin bad++; $display("FAIL stale_tmo: got %0d cycles want 50", n); end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL stale_en2: got rise=%0b want 0", seen); end
    total++; if (layer_rst !== 5'h1f || layer_en !== 5'h00) begin bad++; $display("FAIL stale_outs: got rst=%h en=%h want 1f 00", layer_rst, layer_en); end
    wait_idle();
    force_fin = '0;
  endtask

  task automatic test_timeout();
    int n;
    int d0;
    tmo_limit = TMO_W'(200); model_on = 5'b11101;
    d0 = done_cnt;
    pulse_start();
    wait_en(1, 1'b1, n);
    n = 0;
    while (err !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    total++; if (n !== 200) begin bad++; $display("FAIL tmo_cycles: got %0d want 200", n); end
    total++; if (layer_en !== 5'h00 || layer_rst !== 5'h1f) begin bad++; $display("FAIL tmo_outs: got en=%h rst=%h want 00 1f", layer_en, layer_rst); end
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL tmo_err_hold: got busy=%0b want 1", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || err !== 1'b1) begin bad++; $display("FAIL tmo_idle: got busy=%0b err=%0b want 0 1", busy, err); end
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL tmo_no_done: got %0d want %0d", done_cnt, d0); end
    model_on = '1;
    pulse_start();
    total++; if (err !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rerun_start: got err=%0b busy=%0b want 0 1", err, busy); end
    wait_idle();
    total++; if (done_cnt - d0 !== 1 || err !== 1'b0) begin bad++; $display("FAIL rerun_done: got done=%0d err=%0b want 1 0", done_cnt - d0, err); end
  endtask

  task automatic test_abort_start();
    int n;
    int d0;
    tmo_limit = TMO_W'(1000); model_on = '1;
    d0 = done_cnt;
    pulse_start();
    wait_en(3, 1'b1, n);
    pulse_start();
    @(negedge clk);
    total++; if (layer_en !== 5'b01000 || cur_layer !== 3'd3 || err !== 1'b0) begin bad++; $display("FAIL start_in_run: got en=%b cur=%0d err=%0b want 01000 3 0", layer_en, cur_layer, err); end
    wait_fin(3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (err !== 1'b1 || layer_en !== 5'h00 || layer_rst !== 5'h1f) begin bad++; $display("FAIL abort_vs_fin: got err=%0b en=%h rst=%h want 1 00 1f", err, layer_en, layer_rst); end
    wait_idle();
    total++; if (done_cnt !== d0) begin bad++; $display("FAIL abort_no_done: got %0d want %0d", done_cnt, d0); end
  endtask

  task automatic test_async_reset();
    int n;
    int d0;
    tmo_limit = TMO_W'(1000); model_on = '1;
    pulse_start();
    wait_en(2, 1'b1, n);
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    total++; if (layer_en !== 5'h00 || layer_rst !== 5'h1f) begin bad++; $display("FAIL arst_now: got en=%h rst=%h want 00 1f", layer_en, layer_rst); end
    total++; if (busy !== 1'b0 || cur_layer !== 3'd0) begin bad++; $display("FAIL arst_state: got busy=%0b cur=%0d want 0 0", busy, cur_layer); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || layer_en !== 5'h00 || done_cnt !== d0) begin bad++; $display("FAIL arst_idle: got busy=%0b en=%h done=%0d want 0 00 %0d", busy, layer_en, done_cnt, d0); end
  endtask

  task automatic test_invariants();
    total++; if (inv_bad !== 0) begin bad++; $display("FAIL invariants: got %0d violations want 0", inv_bad); end
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_abort_idle(1'b0);
    test_latency();
    test_stale_finish();
    test_timeout();
    test_abort_start();
    test_abort_idle(1'b1);
    test_async_reset();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
